// File: rtl/cpu_defs_pkg.sv
// Shared CPU definitions: opcodes, instruction field positions and reset PC.
// Also holds the fetch-stage debug state type and field-extraction helpers.
package cpu_defs;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  localparam logic [5:0] OP_JMP   = 6'b010010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_LOAD  = 6'b100011;
  localparam logic [5:0] OP_STORE = 6'b101011;

  localparam int OP_MSB    = 31;
  localparam int OP_LSB    = 26;
  localparam int FUNC_MSB  = 25;
  localparam int FUNC_LSB  = 20;
  localparam int SHAMT_MSB = 19;
  localparam int SHAMT_LSB = 15;
  localparam int RD_MSB    = 14;
  localparam int RD_LSB    = 10;
  localparam int RS_MSB    = 9;
  localparam int RS_LSB    = 5;
  localparam int RT_MSB    = 4;
  localparam int RT_LSB    = 0;
  localparam int IMM16_MSB = 25;
  localparam int IMM16_LSB = 10;
  localparam int JIDX_MSB  = 25;
  localparam int JIDX_LSB  = 0;

  typedef enum logic {
    RUN  = 1'b0,
    HOLD = 1'b1
  } fetch_state_e;

  function automatic logic [5:0] inst_op(input logic [31:0] inst);
    return inst[OP_MSB:OP_LSB];
  endfunction

  function automatic logic [25:0] inst_jidx(input logic [31:0] inst);
    return inst[JIDX_MSB:JIDX_LSB];
  endfunction

endpackage

// File: rtl/next_pc_sel.sv
// Next-PC selection: sequential PC+4, local absolute-jump target build and
// the reset > branch > stall > jump > sequential priority mux.
module next_pc_sel
  import cpu_defs::*;
#(
  parameter logic [31:0] RESET_PC = cpu_defs::RESET_PC,
  parameter logic [5:0]  JMP_OP   = cpu_defs::OP_JMP
) (
  input  logic        rst,
  input  logic        br_taken,
  input  logic        stall,
  input  logic [31:0] br_target,
  input  logic [31:0] pc,
  input  logic [31:0] inst,
  output logic [31:0] pc4,
  output logic [31:0] next_pc
);

  logic        jmp_s;
  logic [31:0] jmp_target_s;

  assign pc4          = pc + 32'd4;
  assign jmp_s        = (inst_op(inst) == JMP_OP);
  assign jmp_target_s = {pc4[31:28], inst_jidx(inst), 2'b00};

  // priority mux for the PC to load at the next edge
  always_comb begin
    next_pc = pc4;
    if (rst) begin
      next_pc = RESET_PC;
    end else if (br_taken) begin
      next_pc = br_target;
    end else if (stall) begin
      next_pc = pc;
    end else if (jmp_s) begin
      next_pc = jmp_target_s;
    end else begin
      next_pc = pc4;
    end
  end

endmodule

// File: rtl/inst_fetch.sv
// Instruction-fetch stage: PC register, IF/ID pipeline register, fetch counter.
// Branch redirects flush IF/ID; stalls freeze PC and IF/ID; jumps resolve locally.
module inst_fetch
  import cpu_defs::*;
#(
  parameter logic [31:0] RESET_PC = cpu_defs::RESET_PC,
  parameter logic [5:0]  JMP_OP   = cpu_defs::OP_JMP
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        br_taken_i,
  input  logic [31:0] br_target_i,
  output logic [31:0] pc_o,
  input  logic [31:0] inst_i,
  output logic [31:0] if_inst_o,
  output logic [31:0] if_pc4_o,
  output logic        if_valid_o,
  output logic [31:0] fetch_cnt_o
);

  logic [31:0]  pc_r;
  logic [31:0]  if_inst_r;
  logic [31:0]  if_pc4_r;
  logic         if_valid_r;
  logic [31:0]  fetch_cnt_r;
  logic [31:0]  pc4_s;
  logic [31:0]  next_pc_s;
  fetch_state_e state_q;
  fetch_state_e state_d;
  logic         unused_dbg_s;

  next_pc_sel #(
    .RESET_PC (RESET_PC),
    .JMP_OP   (JMP_OP)
  ) u_next_pc_sel (
    .rst       (rst),
    .br_taken  (br_taken_i),
    .stall     (stall_i),
    .br_target (br_target_i),
    .pc        (pc_r),
    .inst      (inst_i),
    .pc4       (pc4_s),
    .next_pc   (next_pc_s)
  );

  // debug-only state: HOLD while a stall is not overridden by a redirect
  always_comb begin
    state_d = RUN;
    if (stall_i && !br_taken_i) begin
      state_d = HOLD;
    end else begin
      state_d = RUN;
    end
  end

  // PC, IF/ID register and fetch counter
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_r        <= RESET_PC;
      if_inst_r   <= 32'h0000_0000;
      if_pc4_r    <= 32'h0000_0000;
      if_valid_r  <= 1'b0;
      fetch_cnt_r <= 32'h0000_0000;
      state_q     <= RUN;
    end else begin
      pc_r    <= next_pc_s;
      state_q <= state_d;
      if (br_taken_i) begin
        if_inst_r  <= 32'h0000_0000;
        if_pc4_r   <= 32'h0000_0000;
        if_valid_r <= 1'b0;
      end else if (!stall_i) begin
        if_inst_r   <= inst_i;
        if_pc4_r    <= pc4_s;
        if_valid_r  <= 1'b1;
        fetch_cnt_r <= fetch_cnt_r + 32'd1;
      end
    end
  end

  // state_q is kept only for waveform inspection
  assign unused_dbg_s = ^state_q;

  assign pc_o        = pc_r;
  assign if_inst_o   = if_inst_r;
  assign if_pc4_o    = if_pc4_r;
  assign if_valid_o  = if_valid_r;
  assign fetch_cnt_o = fetch_cnt_r;

endmodule

// File: tb/tb_inst_fetch.sv
// Scoreboard bench for inst_fetch: a per-cycle reference model pushes expected
// post-edge state into a queue; a monitor pops and compares after each edge.
module tb_inst_fetch;
  import cpu_defs::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_i;
  logic        br_taken_i;
  logic [31:0] br_target_i;
  logic [31:0] pc_o;
  logic [31:0] inst_i;
  logic [31:0] if_inst_o;
  logic [31:0] if_pc4_o;
  logic        if_valid_o;
  logic [31:0] fetch_cnt_o;

  logic [31:0] rom [64];

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] pc4;
    logic [31:0] cnt;
    logic        valid;
    logic        hold;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  logic [31:0] m_pc    = 32'h0;
  logic [31:0] m_inst  = 32'h0;
  logic [31:0] m_pc4   = 32'h0;
  logic [31:0] m_cnt   = 32'h0;
  logic        m_valid = 1'b0;
  logic        m_hold  = 1'b0;

  always #5 clk = ~clk;

  assign inst_i = rom[pc_o[7:2]];

  inst_fetch dut (
    .clk         (clk),
    .rst         (rst),
    .stall_i     (stall_i),
    .br_taken_i  (br_taken_i),
    .br_target_i (br_target_i),
    .pc_o        (pc_o),
    .inst_i      (inst_i),
    .if_inst_o   (if_inst_o),
    .if_pc4_o    (if_pc4_o),
    .if_valid_o  (if_valid_o),
    .fetch_cnt_o (fetch_cnt_o)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // monitor: one expected record per clock edge
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      chk("pc_o",        pc_o,                      mon_e.pc);
      chk("if_inst_o",   if_inst_o,                 mon_e.inst);
      chk("if_pc4_o",    if_pc4_o,                  mon_e.pc4);
      chk("if_valid_o",  {31'd0, if_valid_o},       {31'd0, mon_e.valid});
      chk("fetch_cnt_o", fetch_cnt_o,               mon_e.cnt);
      chk("state_q",     {31'd0, dut.state_q == HOLD}, {31'd0, mon_e.hold});
    end
  end

  // drive one cycle of inputs and advance the model to the state after the edge
  task automatic step(input logic r, input logic b, input logic [31:0] t, input logic s);
    logic [31:0] word;
    logic [31:0] p4;
    @(negedge clk);
    rst = r; br_taken_i = b; br_target_i = t; stall_i = s;
    word = rom[m_pc[7:2]];
    p4   = m_pc + 32'd4;
    if (r) begin
      m_pc = 32'h0; m_inst = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0; m_cnt = 32'h0; m_hold = 1'b0;
    end else if (b) begin
      m_pc = t; m_inst = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0; m_hold = 1'b0;
    end else if (s) begin
      m_hold = 1'b1;
    end else begin
      m_inst  = word;
      m_pc4   = p4;
      m_valid = 1'b1;
      m_cnt   = m_cnt + 32'd1;
      m_hold  = 1'b0;
      m_pc    = (word[31:26] == 6'b010010) ? {p4[31:28], word[25:0], 2'b00} : p4;
    end
    exp_q.push_back('{pc: m_pc, inst: m_inst, pc4: m_pc4, cnt: m_cnt, valid: m_valid, hold: m_hold});
  endtask

  initial begin
    logic [31:0] w;
    rst = 1'b1; stall_i = 1'b0; br_taken_i = 1'b0; br_target_i = 32'h0;

    for (int i = 0; i < 64; i++) begin
      w = $urandom;
      if (w[31:26] == 6'b010010) w[31] = 1'b1;
      if (i >= 32 && i < 63 && $urandom_range(0, 5) == 0)
        w = {6'b010010, 20'h0, 6'($urandom_range(0, 63))};
      rom[i] = w;
    end
    rom[9]  = 32'h4800000B;
    rom[20] = 32'h48000005;

    // reset, then free-run through the jump at 0x24 up to 0x30
    step(1'b1, 1'b0, 32'h0, 1'b0);
    step(1'b1, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 30 && m_pc != 32'h30; i++) step(1'b0, 1'b0, 32'h0, 1'b0);
    chk("reach_0x30", m_pc, 32'h30);
    step(1'b0, 1'b1, 32'h28, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b0);

    // redirect to 0x10, stall three cycles, resume
    step(1'b0, 1'b1, 32'h10, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'h0, 1'b1);
    step(1'b0, 1'b0, 32'h0, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b0);

    // stall together with branch; then branch on a jump word
    step(1'b0, 1'b1, 32'h08, 1'b1);
    step(1'b0, 1'b0, 32'h0, 1'b0);
    step(1'b0, 1'b1, 32'h50, 1'b0);
    step(1'b0, 1'b1, 32'h08, 1'b1);
    step(1'b0, 1'b0, 32'h0, 1'b0);

    // stall on the jump word at 0x50, then take it
    step(1'b0, 1'b1, 32'h50, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    step(1'b0, 1'b0, 32'h0, 1'b0);

    // PC wrap at the top of the address space, misaligned target
    step(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b0);
    step(1'b0, 1'b1, 32'h0000_0013, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b0);

    // reset while stalled
    step(1'b0, 1'b0, 32'h0, 1'b1);
    step(1'b1, 1'b0, 32'h0, 1'b1);
    step(1'b0, 1'b0, 32'h0, 1'b0);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 99) == 0),
           ($urandom_range(0, 9) == 0),
           ($urandom_range(0, 1) == 1) ? {24'h0, 8'($urandom)} : 32'($urandom),
           ($urandom_range(0, 3) == 0));
    end
    step(1'b0, 1'b0, 32'h0, 1'b0);

    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(posedge clk);
    #2;
    if (exp_q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d expected records left, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
